// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// opcode field position and the two-byte opcode marker.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    VEC   = 2'd3
  } fetch_state_e;

  localparam logic [3:0] LONG_OPC_DEFAULT = 4'hC;
  localparam int         OPC_MSB          = 7;
  localparam int         OPC_LSB          = 4;

  // True when an opcode byte announces a trailing second byte.
  function automatic logic is_long_opc(input logic [7:0] opc_byte,
                                       input logic [3:0] long_opc);
    return opc_byte[OPC_MSB:OPC_LSB] == long_opc;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, decode and execute.
// master = fetch_unit side, slave = environment (memory / pipeline) side.
interface fetch_unit_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid;
  logic [DW-1:0] imem_data;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [DW-1:0] ir_new;
  logic          sf1_out;
  logic          ld;
  logic [AW-1:0] pc_out;

  modport master (
    output imem_req, imem_addr, ir_new, sf1_out, ld, pc_out,
    input  imem_valid, imem_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, ir_new, sf1_out, ld, pc_out,
    output imem_valid, imem_data, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry holding register for a fetched byte and its second-byte tag,
// used while decode stalls.
module fetch_hold_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] load_data,
  input  logic          load_sf1,
  output logic [DW-1:0] held_data,
  output logic          held_sf1
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_data <= '0;
      held_sf1  <= 1'b0;
    end else if (clear) begin
      held_data <= '0;
      held_sf1  <= 1'b0;
    end else if (load) begin
      held_data <= load_data;
      held_sf1  <= load_sf1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: byte reads from imem, PC tracking, stall/redirect
// handling and second-byte tagging. Optional macro: FETCH_RESET_VECTOR_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int            AW       = 8,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [3:0]    LONG_OPC = LONG_OPC_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

`ifdef FETCH_RESET_VECTOR_EN
  localparam fetch_state_e START_STATE = VEC;
`else
  localparam fetch_state_e START_STATE = FETCH;
`endif

  fetch_state_e  state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic          req_q, req_nxt;
  logic          ld_q, ld_nxt;
  logic [DW-1:0] ir_q, ir_nxt;
  logic          sf1_q, sf1_nxt;
  logic          expect_second, expect_nxt;

  logic          hold_load, hold_clear;
  logic [DW-1:0] held_data;
  logic          held_sf1;

  logic          resp;
  logic          outstanding;
  logic          opc_long;

  assign resp        = req_q && bus.imem_valid;
  assign outstanding = req_q && !bus.imem_valid;
  assign opc_long    = is_long_opc(bus.imem_data[7:0], LONG_OPC);

  fetch_hold_buf #(.DW(DW)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_data (bus.imem_data),
    .load_sf1  (expect_second),
    .held_data (held_data),
    .held_sf1  (held_sf1)
  );

  // NOTE: every always_comb output gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ld_nxt     = 1'b0;
    ir_nxt     = ir_q;
    sf1_nxt    = sf1_q;
    expect_nxt = expect_second;
    hold_load  = 1'b0;
    hold_clear = 1'b0;

    if (bus.redirect) begin
      pc_nxt     = bus.redirect_pc;
      hold_clear = 1'b1;
      expect_nxt = 1'b0;
      if (state == DRAIN) begin
        state_nxt = bus.imem_valid ? FETCH : DRAIN;
      end else begin
        // A request already in flight cannot be withdrawn; its reply must be dropped.
        state_nxt = outstanding ? DRAIN : FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (resp) begin
            pc_nxt     = pc + AW'(1);
            expect_nxt = expect_second ? 1'b0 : opc_long;
            if (bus.stall) begin
              hold_load = 1'b1;
              state_nxt = HOLD;
            end else begin
              ld_nxt  = 1'b1;
              ir_nxt  = bus.imem_data;
              sf1_nxt = expect_second;
            end
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            ld_nxt     = 1'b1;
            ir_nxt     = held_data;
            sf1_nxt    = held_sf1;
            hold_clear = 1'b1;
            state_nxt  = FETCH;
          end
        end
        DRAIN: begin
          if (bus.imem_valid) state_nxt = FETCH;
        end
`ifdef FETCH_RESET_VECTOR_EN
        VEC: begin
          if (resp) begin
            pc_nxt    = AW'(bus.imem_data);
            state_nxt = FETCH;
          end
        end
`endif
        default: state_nxt = FETCH;
      endcase
    end

    req_nxt = (state_nxt == FETCH) || (state_nxt == VEC);
  end

  // imem_req is registered so it reads 0 during reset and rises one cycle after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= START_STATE;
      pc            <= RESET_PC;
      req_q         <= 1'b0;
      ld_q          <= 1'b0;
      ir_q          <= '0;
      sf1_q         <= 1'b0;
      expect_second <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      req_q         <= req_nxt;
      ld_q          <= ld_nxt;
      ir_q          <= ir_nxt;
      sf1_q         <= sf1_nxt;
      expect_second <= expect_nxt;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc;
  assign bus.ld        = ld_q;
  assign bus.ir_new    = ir_q;
  assign bus.sf1_out   = sf1_q;
  assign bus.pc_out    = pc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Issues byte reads to instruction memory and tracks the PC.
- Delivers each fetched byte to the instruction register through ir_new / sf1_out / ld.
- Tags the second byte of two-byte instructions with sf1_out.
- Handles stall from decode and redirect (branch/flush) from execute. Redirect is normally asserted in the same cycle as the instruction register's flush.

Parameters:
- AW, 8, instruction address width.
- DW, 8, instruction byte width (fixed 8; parameter documents intent).
- RESET_PC, 8'h00, PC value after reset.
- LONG_OPC, 4'hC, opcode[7:4] value marking a two-byte instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  AW  read address; equals pc while imem_req=1.
- imem_valid  in  1  read data valid; may be high in the same cycle as imem_req (zero-wait memory).
- imem_data  in  DW  read data, sampled when imem_valid=1.
- stall  in  1  decode cannot accept a byte this cycle.
- redirect  in  1  discard the fetch stream and restart at redirect_pc.
- redirect_pc  in  AW  new fetch address.
- ir_new  out  DW  byte to the instruction register.
- sf1_out  out  1  1 when ir_new is the second byte of a two-byte instruction.
- ld  out  1  load strobe to the instruction register.
- pc_out  out  AW  address of the next byte to fetch, for branch arithmetic.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=FETCH, imem_req=0, ld=0, ir_new=0, sf1_out=0, expect_second=0, hold register cleared.
- States: FETCH, HOLD, DRAIN; plus VEC under the optional feature.
- FETCH:
  - imem_req=1, imem_addr=pc. Address is stable until imem_valid is seen.
  - On imem_valid with stall=0: ir_new<=imem_data, ld<=1 for exactly one cycle, pc<=pc+1.
  - On imem_valid with stall=1: byte goes into the hold register, pc<=pc+1, go to HOLD.
- HOLD:
  - imem_req=0, ld=0 while stall=1.
  - First cycle with stall=0: ld=1 with the held byte, return to FETCH.
- sf1 tagging:
  - A byte delivered with expect_second=0 gets sf1_out=0.
  - If that byte's [7:4]==LONG_OPC, set expect_second=1.
  - The next delivered byte gets sf1_out=1 and clears expect_second.
  - A second byte is never itself decoded as an opcode.
- ld timing: registered output; ir_new and sf1_out are valid and stable while ld=1.
- PC arithmetic: modulo 2^AW; 8'hFF+1 wraps to 8'h00.
- Priority: reset > redirect > stall > normal fetch.
- Redirect (any state):
  - pc<=redirect_pc, ld=0 that cycle.
  - Hold register and expect_second cleared.
  - If a request is outstanding (imem_req=1, imem_valid=0), go to DRAIN. Otherwise go to FETCH.
- DRAIN:
  - Memory is in-order and requests cannot be withdrawn, so the stale response is discarded.
  - imem_req=0; wait for imem_valid, drop the data, go to FETCH.
  - A further redirect in DRAIN only updates pc.
- imem_valid in the same cycle as redirect: data discarded, no DRAIN.
- Stall in FETCH with no response yet: request stays high; the response is captured into HOLD.
- Reset mid-transaction: any outstanding memory response after reset is the memory's responsibility; the memory is reset by the same rst.

Optional Feature:
- FETCH_RESET_VECTOR_EN defined:
  - After reset the state is VEC. Read address RESET_PC.
  - The returned byte is loaded into pc; no ld is issued.
  - Then go to FETCH.
  - redirect during VEC behaves as in FETCH: the vector is abandoned and fetch starts at redirect_pc.
- Not defined: fetch starts directly at RESET_PC in FETCH.

Decomposition:
- Shared package/header:
  - State encodings FETCH/HOLD/DRAIN/VEC.
  - LONG_OPC default.
  - Opcode field position [7:4].
- Sub-module fetch_hold_buf: one-entry byte + sf1 holding register with load/clear, used for HOLD.
- Everything else stays in fetch_unit.

Test Plan:
- Zero-wait memory with bytes 8'h12 at 0, 8'h34 at 1 -> ld high two consecutive cycles, ir_new=12 then 34, sf1_out=0 both, pc_out=2.
- Two-byte instruction: bytes 8'hC5, 8'h7F -> ir_new=C5 with sf1_out=0, then 7F with sf1_out=1. Next byte 8'hC0 gets sf1_out=0.
- stall=1 for 3 cycles while memory returns 8'hAA -> no ld during stall. ld=1 with AA on the first stall=0 cycle. pc incremented once only.
- Memory 2-cycle latency with redirect to 8'h40 one cycle after req -> DRAIN entered, stale byte never reaches ld, next imem_addr=40.
- pc=8'hFF fetch -> after accept pc_out=8'h00, next imem_addr=8'h00.
- With FETCH_RESET_VECTOR_EN, mem[0]=8'h80 -> no ld for the vector byte, first fetch address 8'h80. Assert rst=0 mid-fetch -> outputs return to reset values immediately, without waiting for clk.
